hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage core, sitting between the ID and EX stages. It generates the PC, IF/ID and ID/EX enable and flush controls. It covers three cases:
- load-use stalls lasting a configurable number of cycles, for slower data memories;
- freezes while a multi-cycle EX unit (divider) is busy;
- wrong-path flushes on a taken branch.

A saturating stall-cycle performance counter is included.

## Interface
Parameters:
- REG_W, 5, register-address width.
- LOAD_LATENCY, 1, load-use stall cycles. Legal range 1..4.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs1_id, rs2_id  in  REG_W  source registers of the instruction in ID.
- rs1_used, rs2_used  in  1  the ID instruction actually reads rs1 / rs2.
- rd_ex  in  REG_W  destination register of the instruction in EX.
- mem_read_ex  in  1  the instruction in EX is a load.
- ex_busy  in  1  the multi-cycle EX unit is still computing.
- branch_taken_ex  in  1  a branch/jump resolved taken in EX this cycle.
- stall_cnt_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_flush  out  1  load a bubble into ID/EX.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

## Operation
- State machine states: IDLE, LOAD_WAIT. Down-counter wait_cnt, width 2 bits.
- Outputs are Mealy: combinational from state, wait_cnt and the current inputs.
- load_hazard is true when all of the following hold:
  - mem_read_ex = 1;
  - rd_ex != 0;
  - (rs1_used and rd_ex == rs1_id) or (rs2_used and rd_ex == rs2_id).
- Output priority, highest first:
  1. branch_taken_ex: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=1, id_ex_flush=1. Next state IDLE and wait_cnt=0; this aborts any LOAD_WAIT.
  2. ex_busy: pc_write=0, if_id_write=0, id_ex_write=0, both flushes 0. State and wait_cnt are held.
  3. state LOAD_WAIT: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, if_id_flush=0. wait_cnt decrements. When wait_cnt==1, next state is IDLE. load_hazard is not re-evaluated in this state.
  4. IDLE with load_hazard: same outputs as LOAD_WAIT. If LOAD_LATENCY>1, next state LOAD_WAIT with wait_cnt=LOAD_LATENCY-1; otherwise stay IDLE.
  5. Otherwise: all writes 1, all flushes 0.
- Total load-use stall length is exactly LOAD_LATENCY cycles, excluding cycles frozen by ex_busy.
- stall_count:
  - +1 on each edge where pc_write=0;
  - saturates at 2^CNT_W-1 (no wrap);
  - stall_cnt_clr takes priority over the increment and sets it to 0.
- rd_ex = 0 never triggers a stall, even when mem_read_ex=1.
- An unused source register never triggers a stall.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, wait_cnt=0, stall_count=0;
  - with idle inputs: pc_write=if_id_write=id_ex_write=1, if_id_flush=id_ex_flush=0.
- Hazard-to-control latency is 0 cycles: outputs respond in the same cycle the inputs change.
- The state update takes effect from the next rising edge.
- Deassertion of rst_n mid-stall: the unit resumes in IDLE with no residual stall.
- ex_busy during LOAD_WAIT: wait_cnt is frozen, and the load stall resumes once ex_busy drops.
- branch_taken_ex and load_hazard in the same cycle: the flush wins and no stall is started.

## Test plan
- Load-use, LOAD_LATENCY=1: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used=1 for one cycle -> exactly 1 cycle of pc_write=0, id_ex_flush=1; stall_count=1.
- Load-use, LOAD_LATENCY=3: same stimulus, held for one cycle -> 3 consecutive stall cycles, then pc_write=1; stall_count=3.
- No false stalls:
  - rd_ex=0 -> no stall;
  - rd_ex=7, rs2_id=7, rs2_used=0 -> no stall;
  - mem_read_ex=0 -> no stall.
- ex_busy held 4 cycles mid-LOAD_WAIT (LOAD_LATENCY=3, second stall cycle) -> all writes 0 for those 4 cycles, then the remaining stall cycles complete; stall_count=7.
- branch_taken_ex in the same cycle as load_hazard -> if_id_flush=id_ex_flush=1, pc_write=1, state stays IDLE.
- Saturation and clear, CNT_W=4:
  - 20 ex_busy cycles -> stall_count=15;
  - stall_cnt_clr together with a stall cycle -> stall_count=0.
  - rst_n pulsed low mid-LOAD_WAIT -> outputs return immediately to the reset values listed under Timing.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller between ID and EX: load-use stalls, EX-busy freezes,
// taken-branch flushes, and a saturating count of stalled cycles.
module hazard_ctrl_unit #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    input  logic             ex_busy,
    input  logic             branch_taken_ex,
    input  logic             stall_cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              load_hazard;

    assign load_hazard = mem_read_ex && (rd_ex != '0) &&
                         ((rs1_used && (rd_ex == rs1_id)) ||
                          (rs2_used && (rd_ex == rs2_id)));

    // Mealy control: branch flush > EX freeze > ongoing load wait > new load hazard
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nx    = state;
        wait_nx     = wait_cnt;

        if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nx    = IDLE;
            wait_nx     = '0;
        end else if (ex_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (state == LOAD_WAIT) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            wait_nx     = wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1)) begin
                state_nx = IDLE;
            end
        end else if (load_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_LATENCY > 1) begin
                state_nx = LOAD_WAIT;
                wait_nx  = WAIT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_cnt_clr) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (latency 1, latency 3, 4-bit counter)
// checked every cycle against a remaining-stall-cycles model plus literal expectations.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used, rs2_used, mem_read_ex, ex_busy, branch_taken_ex, stall_cnt_clr;

    logic       pc_a, ifw_a, idw_a, iff_a, idf_a;
    logic       pc_b, ifw_b, idw_b, iff_b, idf_b;
    logic       pc_c, ifw_c, idw_c, iff_c, idf_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .ex_busy(ex_busy), .branch_taken_ex(branch_taken_ex),
        .stall_cnt_clr(stall_cnt_clr), .pc_write(pc_a), .if_id_write(ifw_a),
        .id_ex_write(idw_a), .if_id_flush(iff_a), .id_ex_flush(idf_a), .stall_count(cnt_a));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LATENCY(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .ex_busy(ex_busy), .branch_taken_ex(branch_taken_ex),
        .stall_cnt_clr(stall_cnt_clr), .pc_write(pc_b), .if_id_write(ifw_b),
        .id_ex_write(idw_b), .if_id_flush(iff_b), .id_ex_flush(idf_b), .stall_count(cnt_b));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LATENCY(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .ex_busy(ex_busy), .branch_taken_ex(branch_taken_ex),
        .stall_cnt_clr(stall_cnt_clr), .pc_write(pc_c), .if_id_write(ifw_c),
        .id_ex_write(idw_c), .if_id_flush(iff_c), .id_ex_flush(idf_c), .stall_count(cnt_c));

    // Model: each instance owes a number of further load-stall cycles and keeps a count
    int ll   [3] = '{1, 3, 3};
    int maxc [3] = '{65535, 65535, 15};
    int rem  [3];
    int mcnt [3];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic hz();
        return mem_read_ex && (rd_ex != 5'd0) &&
               ((rs1_used && rd_ex == rs1_id) || (rs2_used && rd_ex == rs2_id));
    endfunction

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush}
    function automatic logic [4:0] exp_ctl(int i);
        if (branch_taken_ex)        return 5'b11111;
        if (ex_busy)                return 5'b00000;
        if (rem[i] > 0 || hz())     return 5'b00101;
        return 5'b11100;
    endfunction

    function automatic logic [4:0] act_ctl(int i);
        case (i)
            0:       return {pc_a, ifw_a, idw_a, iff_a, idf_a};
            1:       return {pc_b, ifw_b, idw_b, iff_b, idf_b};
            default: return {pc_c, ifw_c, idw_c, iff_c, idf_c};
        endcase
    endfunction

    function automatic int act_cnt(int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]  = 0;
                mcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [4:0] e;
                e = exp_ctl(i);
                if (branch_taken_ex)  rem[i] = 0;
                else if (ex_busy)     rem[i] = rem[i];
                else if (rem[i] > 0)  rem[i] = rem[i] - 1;
                else if (hz())        rem[i] = ll[i] - 1;
                if (stall_cnt_clr)                      mcnt[i] = 0;
                else if (!e[4] && mcnt[i] < maxc[i])    mcnt[i] = mcnt[i] + 1;
            end
        end
    end

    task automatic compare_model();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (act_ctl(i) !== exp_ctl(i)) begin
                n_err++;
                $display("FAIL ctl[%0d] t=%0t actual=%b expected=%b", i, $time, act_ctl(i), exp_ctl(i));
            end
            n_vec++;
            if (act_cnt(i) != mcnt[i]) begin
                n_err++;
                $display("FAIL cnt[%0d] t=%0t actual=%0d expected=%0d", i, $time, act_cnt(i), mcnt[i]);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic mr,
                          input logic busy, input logic br, input logic clr);
        rs1_id = r1; rs2_id = r2; rd_ex = rd;
        rs1_used = u1; rs2_used = u2; mem_read_ex = mr;
        ex_busy = busy; branch_taken_ex = br; stall_cnt_clr = clr;
    endtask

    // One cycle: drive after the edge, then check the model before the next edge
    task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic mr,
                       input logic busy, input logic br, input logic clr);
        @(posedge clk);
        #1;
        set_in(r1, r2, rd, u1, u2, mr, busy, br, clr);
        #3;
        compare_model();
    endtask

    task automatic idle();       cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic clr();        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic busy();       cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic load_use();   cyc(5, 0, 5, 1, 0, 1, 0, 0, 0); endtask

    typedef struct packed {
        logic [4:0] r1, r2, rd;
        logic u1, u2, mr, busy, br, clr;
    } vec_t;

    vec_t tbl [12] = '{
        '{5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
        '{5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
        '{5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{5'd31, 5'd6, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        compare_model();
        chk("rst_pc_write", int'(pc_b), 1);
        chk("rst_id_ex_flush", int'(idf_b), 0);
        chk("rst_stall_count", int'(cnt_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        clr();

        // Single load-use cycle
        load_use();
        chk("l1_hz_pc_write", int'(pc_a), 0);
        chk("l1_hz_id_ex_flush", int'(idf_a), 1);
        chk("l3_hz_pc_write", int'(pc_b), 0);
        idle();
        chk("l1_after_pc_write", int'(pc_a), 1);
        chk("l3_stall2_pc_write", int'(pc_b), 0);
        idle();
        idle();
        chk("l3_after_pc_write", int'(pc_b), 1);
        chk("l1_stall_count", int'(cnt_a), 1);
        chk("l3_stall_count", int'(cnt_b), 3);

        // No false stalls
        clr();
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 7, 7, 0, 0, 1, 0, 0, 0);
        cyc(5, 0, 5, 1, 0, 0, 0, 0, 0);
        idle();
        chk("no_false_stall_count", int'(cnt_b), 0);

        // EX busy in the middle of a load wait
        clr();
        load_use();
        busy();
        chk("busy_id_ex_write", int'(idw_b), 0);
        busy();
        busy();
        busy();
        idle();
        idle();
        chk("resume_pc_write", int'(pc_b), 0);
        idle();
        chk("resume_done_pc_write", int'(pc_b), 1);
        chk("busy_l3_count", int'(cnt_b), 7);
        chk("busy_l1_count", int'(cnt_a), 5);

        // Branch and load hazard together
        clr();
        cyc(5, 0, 5, 1, 0, 1, 0, 1, 0);
        chk("br_if_id_flush", int'(iff_b), 1);
        chk("br_id_ex_flush", int'(idf_b), 1);
        chk("br_pc_write", int'(pc_b), 1);
        idle();
        chk("br_next_pc_write", int'(pc_b), 1);
        chk("br_next_id_ex_flush", int'(idf_b), 0);
        chk("br_count", int'(cnt_b), 0);

        // Saturation and clear
        clr();
        repeat (20) busy();
        idle();
        chk("sat_count", int'(cnt_c), 15);
        chk("nosat_count", int'(cnt_b), 20);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle();
        chk("clr_sat_count", int'(cnt_c), 0);
        chk("clr_l3_count", int'(cnt_b), 0);

        // Reset in the middle of a load wait
        load_use();
        idle();
        chk("pre_rst_pc_write", int'(pc_b), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pc_write", int'(pc_b), 1);
        chk("rst_mid_if_id_write", int'(ifw_b), 1);
        chk("rst_mid_id_ex_write", int'(idw_b), 1);
        chk("rst_mid_id_ex_flush", int'(idf_b), 0);
        chk("rst_mid_if_id_flush", int'(iff_b), 0);
        chk("rst_mid_count", int'(cnt_b), 0);
        compare_model();
        #2;
        rst_n = 1'b1;
        idle();
        chk("post_rst_pc_write", int'(pc_b), 1);

        // Mixed directed vectors checked against the model
        foreach (tbl[k]) begin
            cyc(tbl[k].r1, tbl[k].r2, tbl[k].rd, tbl[k].u1, tbl[k].u2,
                tbl[k].mr, tbl[k].busy, tbl[k].br, tbl[k].clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
